// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: ALU operation codes and the ID/EX pipeline bundle.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;
  localparam int RAW  = 5;

  localparam logic [OPW-1:0] ALU_AND = 4'b0000;
  localparam logic [OPW-1:0] ALU_OR  = 4'b0001;
  localparam logic [OPW-1:0] ALU_ADD = 4'b0010;
  localparam logic [OPW-1:0] ALU_XOR = 4'b0011;
  localparam logic [OPW-1:0] ALU_SUB = 4'b0100;
  localparam logic [OPW-1:0] ALU_SLT = 4'b0101;
  localparam logic [OPW-1:0] ALU_SLL = 4'b0110;
  localparam logic [OPW-1:0] ALU_SRL = 4'b0111;
  localparam logic [OPW-1:0] ALU_EQ  = 4'b1000;
  localparam logic [OPW-1:0] ALU_SRA = 4'b1001;
  localparam logic [OPW-1:0] ALU_NE  = 4'b1010;

  // Everything captured at the ID->EX boundary; an all-zero value is a bubble.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic [RAW-1:0]  rd_addr;
    logic [XLEN-1:0] imm;
    logic            src_a_pc;
    logic            src_b_imm;
    logic [OPW-1:0]  alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_t;

endpackage

// File: rtl/forward_unit.sv
// Per-source bypass select: EX/MEM beats MEM/WB, x0 is never bypassed.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int REG_ADDR_W = RAW
) (
  input  logic                  i_fwd_en,
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_exmem_reg_write,
  input  logic [DATA_WIDTH-1:0] i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic                  i_memwb_reg_write,
  input  logic [DATA_WIDTH-1:0] i_memwb_result,
  output logic [DATA_WIDTH-1:0] o_operand
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_hit_exmem = i_fwd_en & i_exmem_reg_write & (i_exmem_rd != '0) &
                       (i_exmem_rd == i_rs_addr);
  assign w_hit_memwb = i_fwd_en & i_memwb_reg_write & (i_memwb_rd != '0) &
                       (i_memwb_rd == i_rs_addr);

  always_comb begin
    o_operand = i_rs_data;
    if (w_hit_exmem)      o_operand = i_exmem_result;
    else if (w_hit_memwb) o_operand = i_memwb_result;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand select, bypass and load-use bubble insertion.
// ALU_FORWARDING_EN enables the bypass; without it, RAW hazards stall instead.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int OPCODE_LENGTH = OPW,
  parameter int REG_ADDR_W    = RAW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
  input  logic [REG_ADDR_W-1:0]    id_rd_addr,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_src_a_pc,
  input  logic                     id_src_b_imm,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic                     exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [REG_ADDR_W-1:0]    ex_rd_addr,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic                     hazard_stall
);

`ifdef ALU_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  id_ex_t                r_ex;
  id_ex_t                w_ex_load;
  id_ex_t                w_ex_next;
  logic                  w_load_use;
  logic                  w_raw_dep;
  logic [DATA_WIDTH-1:0] w_fwd_rs1;
  logic [DATA_WIDTH-1:0] w_fwd_rs2;

  assign w_load_use = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd_addr != '0) &
                      ((r_ex.rd_addr == id_rs1_addr) | (r_ex.rd_addr == id_rs2_addr));

  // Without bypass, any in-flight writer of a source must drain before ID advances.
  always_comb begin
    w_raw_dep = 1'b0;
    if (!FWD_EN && id_valid) begin
      w_raw_dep = ((id_rs1_addr != '0) &
                   ((r_ex.valid & r_ex.reg_write & (r_ex.rd_addr == id_rs1_addr)) |
                    (exmem_reg_write & (exmem_rd == id_rs1_addr)))) |
                  ((id_rs2_addr != '0) &
                   ((r_ex.valid & r_ex.reg_write & (r_ex.rd_addr == id_rs2_addr)) |
                    (exmem_reg_write & (exmem_rd == id_rs2_addr))));
    end
  end

  assign hazard_stall = w_load_use | w_raw_dep;

  always_comb begin
    w_ex_load           = '0;
    w_ex_load.valid     = id_valid;
    w_ex_load.pc        = id_pc;
    w_ex_load.rs1_data  = id_rs1_data;
    w_ex_load.rs2_data  = id_rs2_data;
    w_ex_load.rs1_addr  = id_rs1_addr;
    w_ex_load.rs2_addr  = id_rs2_addr;
    w_ex_load.rd_addr   = id_rd_addr;
    w_ex_load.imm       = id_imm;
    w_ex_load.src_a_pc  = id_src_a_pc;
    w_ex_load.src_b_imm = id_src_b_imm;
    w_ex_load.alu_op    = id_alu_op;
    w_ex_load.reg_write = id_reg_write & id_valid;
    w_ex_load.mem_read  = id_mem_read & id_valid;
    w_ex_load.mem_write = id_mem_write & id_valid;
  end

  // flush > stall > hazard bubble > load
  always_comb begin
    w_ex_next = w_ex_load;
    if (flush)             w_ex_next = '0;
    else if (stall)        w_ex_next = r_ex;
    else if (hazard_stall) w_ex_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex <= '0;
    else        r_ex <= w_ex_next;
  end

  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_fwd_en          (FWD_EN),
    .i_rs_addr         (r_ex.rs1_addr),
    .i_rs_data         (r_ex.rs1_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_operand         (w_fwd_rs1)
  );

  forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_fwd_en          (FWD_EN),
    .i_rs_addr         (r_ex.rs2_addr),
    .i_rs_data         (r_ex.rs2_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_operand         (w_fwd_rs2)
  );

  assign SrcA          = r_ex.src_a_pc  ? r_ex.pc  : w_fwd_rs1;
  assign SrcB          = r_ex.src_b_imm ? r_ex.imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;
  assign Operation     = r_ex.alu_op;
  assign ex_valid      = r_ex.valid;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_rd_addr    = r_ex.rd_addr;
  assign ex_pc         = r_ex.pc;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register with operand-select and forwarding logic. It sits directly upstream of the ALU.
- Registers the decoded instruction, then combinationally drives SrcA, SrcB and Operation, resolving RAW hazards from EX/MEM and MEM/WB by bypass.
- Detects load-use hazards and inserts a bubble into EX.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, ALU operation code width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode-stage instruction valid.
- id_pc  in  DATA_WIDTH  instruction PC.
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register file read data.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_W  source/destination indices.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_src_a_pc  in  1  SrcA = PC (AUIPC/JAL).
- id_src_b_imm  in  1  SrcB = immediate.
- id_alu_op  in  OPCODE_LENGTH  ALU operation code.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- stall  in  1  external hold (e.g. memory wait).
- flush  in  1  branch/jump redirect; kill the instruction entering EX.
- exmem_rd  in  REG_ADDR_W; exmem_reg_write  in  1; exmem_result  in  DATA_WIDTH.
- memwb_rd  in  REG_ADDR_W; memwb_reg_write  in  1; memwb_result  in  DATA_WIDTH.
- SrcA, SrcB  out  DATA_WIDTH  ALU operands.
- Operation  out  OPCODE_LENGTH  ALU op.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1.
- ex_rd_addr  out  REG_ADDR_W.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value.
- ex_pc  out  DATA_WIDTH.
- hazard_stall  out  1  to fetch/decode: hold IF/ID this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registered fields clear to 0, so ex_valid=0 and all control bits are 0.
  - Operation=4'b0000, SrcA=SrcB=0 (no forwarding match possible at reset).
  - hazard_stall=0.
- Per-edge update priority: flush > stall > hazard bubble > load.
  - flush: load a bubble. valid, reg_write, mem_read, mem_write=0; data fields=0; Operation=0.
  - stall (no flush): hold all registers.
  - hazard_stall (no flush/stall): load a bubble.
  - otherwise: load all id_* fields; ex_valid=id_valid; control bits gated by id_valid.
- Load-use detection is combinational:
  - hazard_stall = ex_valid & ex_mem_read & (ex_rd_addr!=0) & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr) & id_valid.
  - It does not consider id_src_a_pc/id_src_b_imm (conservative).
- Forwarding per source, combinational, using the registered rs addresses:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==rs: use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs: use memwb_result.
  - Else use the registered read data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand select:
  - SrcA = ex_src_a_pc ? ex_pc : fwd_rs1.
  - SrcB = ex_src_b_imm ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Operation = registered op; pure pass-through. The stage adds 1 cycle latency ID->EX.
- Register file is write-through: a same-cycle WB write is visible on id_rs*_data. The stage does not handle WB->ID.
- Reset asserted mid-stall or mid-hazard: state clears immediately; stall resumes from an empty EX.

Optional Feature:
- Macro: ALU_FORWARDING_EN.
- Defined: forwarding as above.
- Undefined:
  - No bypass muxes; fwd_rs* = registered read data.
  - hazard_stall additionally asserts when id_valid and a nonzero id rs matches either:
    - a valid EX rd with ex_reg_write, or
    - exmem_rd with exmem_reg_write.
  - Bubble insertion is identical.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU op localparams (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_XOR=4'b0011, ALU_SUB=4'b0100, ALU_SLT=4'b0101, ALU_SLL=4'b0110, ALU_SRL=4'b0111, ALU_EQ=4'b1000, ALU_SRA=4'b1001, ALU_NE=4'b1010).
  - struct id_ex_t for the registered bundle.
- One sub-module, forward_unit: a pure combinational per-source select, instantiated twice.

Test Plan:
- Reset with rst_n=0 mid-cycle, inputs active -> ex_valid=0 and all outputs 0 immediately, independent of clk.
- ID add x3=x1+x2 (rs1_data=5, rs2_data=7, op=0010), no hazards -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
- Forwarding: EX instr rs1=3 with exmem_rd=3 (result 0x10) and memwb_rd=3 (result 0x20), both reg_write -> SrcA=0x10. Same case with exmem_rd=0 -> SrcA=0x20.
- Load-use: EX=lw x5 (mem_read=1), ID rs2=5 -> hazard_stall=1; next edge ex_valid=0 and reg_write=0; following edge loads the held ID instruction.
- flush=1 and stall=1 together with a valid ID instruction -> next edge bubble (ex_valid=0), not hold.
- ALU_FORWARDING_EN undefined: ID rs1=4 while EX holds valid reg_write rd=4 -> hazard_stall=1; with rd=0 -> hazard_stall=0.
